// File: rtl/id_hazard_ctrl.sv
// =============================================================================
// Module   : id_hazard_ctrl
// Purpose  : ID-stage scoreboard hazard controller with stall watchdog.
//            Optional stall statistics enabled by defining HAZARD_STATS_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module id_hazard_ctrl #(
   parameter int NUM_REGS    = 16,
   parameter int CNT_W       = 2,
   parameter int STALL_LIMIT = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic                id_reg1_read,
   input  logic [3:0]          id_reg1_addr,
   input  logic                id_reg2_read,
   input  logic [3:0]          id_reg2_addr,
   input  logic                id_wreg,
   input  logic [3:0]          id_wd,
   input  logic                wb_wreg,
   input  logic [3:0]          wb_wd,
   input  logic                flush,
   output logic                stall_o,
   output logic                bubble_o,
   output logic                issue_o,
   output logic [NUM_REGS-1:0] busy_o,
   output logic                timeout_o,
   output logic [15:0]         stall_cnt_o
);

   localparam int             AW      = 4;
   localparam int             WD_W    = $clog2(STALL_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_STALL = 2'd1,
      S_HUNG  = 2'd2
   } state_t;

   logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_REGS-1:0][CNT_W-1:0] eff_w;
   logic [NUM_REGS-1:0]            wb_hit_w;
   logic                           raw_w, ovf_w;

   state_t                         state_q, state_d;
   logic [WD_W-1:0]                wd_q, wd_d, wd_inc_w;
   logic                           timeout_q, timeout_d;

   // A writeback to an idle register is ignored, so it never lowers eff below 0.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         wb_hit_w[r] = wb_wreg && (wb_wd == AW'(r)) && (cnt_q[r] != '0);
         eff_w[r]    = cnt_q[r] - CNT_W'(wb_hit_w[r]);
         busy_o[r]   = (cnt_q[r] != '0);
      end
   end

   always_comb begin
      raw_w = id_valid &&
              ((id_reg1_read && (eff_w[id_reg1_addr] != '0)) ||
               (id_reg2_read && (eff_w[id_reg2_addr] != '0)));
      ovf_w = id_valid && id_wreg && (id_wd != '0) && (eff_w[id_wd] == CNT_MAX);
   end

   assign stall_o  = (raw_w || ovf_w) && !flush && !rst;
   assign bubble_o = stall_o;
   assign issue_o  = id_valid && !stall_o && !flush && !rst;

   always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = '0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (issue_o && id_wreg && (id_wd == AW'(r)) && !wb_hit_w[r])
               cnt_d[r] = cnt_q[r] + 1'b1;
            else if (wb_hit_w[r] && !(issue_o && id_wreg && (id_wd == AW'(r))))
               cnt_d[r] = cnt_q[r] - 1'b1;
         end
      end
      cnt_d[0] = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign wd_inc_w = wd_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      wd_d      = wd_q;
      timeout_d = timeout_q;
      if (flush) begin
         state_d   = S_RUN;
         wd_d      = '0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            S_RUN, S_STALL: begin
               if (stall_o) begin
                  wd_d = wd_inc_w;
                  if (wd_inc_w >= WD_W'(STALL_LIMIT)) begin
                     state_d   = S_HUNG;
                     timeout_d = 1'b1;
                  end else begin
                     state_d = S_STALL;
                  end
               end else begin
                  state_d = S_RUN;
                  wd_d    = '0;
               end
            end
            S_HUNG: begin
               if (!stall_o) begin
                  state_d = S_RUN;
                  wd_d    = '0;
               end
            end
            default: begin
               state_d = S_RUN;
               wd_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_RUN;
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_cnt_q;

   // Survives flush on purpose: only reset clears the statistic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt_q <= '0;
      else if (stall_o && (stall_cnt_q != 16'hFFFF))
         stall_cnt_q <= stall_cnt_q + 16'd1;
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Pipeline hazard controller between the ID stage and the register file. It keeps a per-register scoreboard of writes that have issued but not yet written back. It stalls IF/ID and injects a bubble into EX when an instruction in ID reads, or would overflow, a pending register. It also provides a stall-watchdog and optional stall statistics.

## Interface
Parameters:
- `NUM_REGS`, 16: architectural registers; addresses are 4 bits.
- `CNT_W`, 2: width of the per-register pending counter; maximum in-flight writes per register is 2^CNT_W-1.
- `STALL_LIMIT`, 64: consecutive stall cycles that trigger the watchdog.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_reg1_read` in 1: ID read-port-1 enable.
- `id_reg1_addr` in 4: ID read-port-1 address.
- `id_reg2_read` in 1: ID read-port-2 enable.
- `id_reg2_addr` in 4: ID read-port-2 address.
- `id_wreg` in 1: ID instruction writes a register.
- `id_wd` in 4: ID destination address.
- `wb_wreg` in 1: writeback write enable.
- `wb_wd` in 4: writeback destination address.
- `flush` in 1: pipeline flush; all in-flight instructions are killed and never write back.
- `stall_o` out 1: hold PC and the IF/ID register.
- `bubble_o` out 1: ID/EX loads NOP this cycle.
- `issue_o` out 1: ID instruction advances to EX this cycle.
- `busy_o` out 16: bit i set while register i has a pending write.
- `timeout_o` out 1: sticky watchdog flag.
- `stall_cnt_o` out 16: total stall cycles, saturating.

## Operation
- Address 0 is the NOP register address. It is never tracked, never causes a hazard, and its busy bit is always 0.
- **Effective pending count** `eff[r]`:
  - `eff[r] = cnt[r] - 1` when `wb_wreg` is set and `wb_wd == r`.
  - Otherwise `eff[r] = cnt[r]`.
  - The regfile writes through, so a read matching the same-cycle writeback is not a hazard.
- **RAW hazard**: `id_valid`, and either `id_reg1_read` with `eff[id_reg1_addr] != 0`, or `id_reg2_read` with `eff[id_reg2_addr] != 0`.
- **Overflow hazard**: `id_valid && id_wreg && eff[id_wd] == max`.
- **Stall and issue outputs**:
  - `stall_o = bubble_o = (RAW | overflow) && !flush`.
  - `issue_o = id_valid && !stall_o && !flush`.
- **Counter update at each rising edge**:
  - +1 for `id_wd` when `issue_o && id_wreg`.
  - −1 for `wb_wd` when `wb_wreg`.
  - Both on the same register: unchanged.
  - A writeback to a register whose count is 0 is ignored; the counter never underflows.
- **flush**: all counters are cleared to 0 at the edge. It overrides every other update.

FSM states and transitions:
- **RUN**: enter STALL when `stall_o` is 1.
- **STALL**: the watchdog counter increments each stall cycle.
  - Return to RUN when `stall_o` is 0; the watchdog clears.
  - When the watchdog reaches `STALL_LIMIT`, set `timeout_o` and enter HUNG.
- **HUNG**: `stall_o` keeps following the hazard logic. Leave to RUN on `flush` or when `stall_o` is 0. `timeout_o` remains set.
- **flush**: from any state, next state is RUN and the watchdog clears. `timeout_o` clears only on `flush` or `rst`.

## Timing
- `stall_o`, `bubble_o` and `issue_o` are combinational from the inputs and registered state, with zero latency. A hazard stalls the same cycle it appears in ID.
- Scoreboard, FSM, `timeout_o` and `stall_cnt_o` update on the rising edge. `busy_o` reflects the registered counters one cycle after issue or writeback.
- Back-to-back dependent instructions: the consumer stalls until the cycle in which the producer's `wb_wreg` pulses, then issues that cycle.
- Reset values: all counters 0, state RUN, `busy_o` 0, `timeout_o` 0, `stall_cnt_o` 0.
- Combinational outputs during reset: `stall_o` 0, `bubble_o` 0, `issue_o` 0.
- Reset asserted mid-stall clears everything immediately (asynchronous). The instruction in ID re-evaluates against the empty scoreboard after release.

## Configuration
- `HAZARD_STATS_EN`:
  - Defined: `stall_cnt_o` increments by 1 on every rising edge where `stall_o` is 1, saturating at 16'hFFFF. It is not cleared by `flush`, only by `rst`.
  - Undefined: the counter is not built and `stall_cnt_o` is tied to 16'h0000.
- Scoreboard, FSM and watchdog are unaffected by the macro.

## Test plan
1. **Issue write, then dependent read.** Stimulus: issue a write to r3; next cycle ID reads r3 with no writeback. Required: `stall_o` = 1, `busy_o` = 16'h0008. When `wb_wreg` = 1 with `wb_wd` = 3: same cycle `stall_o` = 0, `issue_o` = 1; next cycle `busy_o` = 0.
2. **Register 0 untracked.** Stimulus: issue a write to r0, then read r0. Required: `stall_o` stays 0 and `busy_o` stays 0.
3. **Overflow hazard.** Stimulus: with `CNT_W` = 2, issue three writes to r5 with no writeback, then a fourth write to r5. Required: the fourth stalls, and issues in the cycle a writeback to r5 occurs.
4. **Same-cycle issue and writeback.** Stimulus: with r7 count 1, issue a write to r7 while `wb_wd` = 7. Required: r7 count stays 1.
5. **Watchdog and flush.** Stimulus: hold a RAW hazard for 64 cycles. Required: `timeout_o` = 1 and sticky. Then `flush` = 1. Required: next cycle `busy_o` = 0, state RUN, `timeout_o` = 0.
6. **Stall statistics and reset.** With `HAZARD_STATS_EN` defined: 10 stall cycles give `stall_cnt_o` = 10; asserting `rst` mid-stall gives 0 immediately. Undefined: `stall_cnt_o` stays 0.
